// File: rtl/ctrl_burst_data.sv
// Data-burst timing stage behind the CAS controller: queues CAS commands and opens rd/wr windows at RL/WL.
// Optional WR_CRC_EN: write bursts carry one extra CRC clock (BL/2+1 clocks).
//   state   | meaning
//   D_IDLE  | queue empty, no burst
//   D_WAIT  | head queued, waiting for its start stamp
//   D_BURST | window open, beat_idx counting
module ctrl_burst_data #(
  parameter int Q_DEPTH = 4,
  parameter int TS_W    = 8
) (
  input  logic       CK_t,
  input  logic       reset_n,
  input  logic       cas_rdy,
  input  logic [2:0] cas_req,
  input  logic [4:0] CL,
  input  logic [4:0] AL,
  input  logic [4:0] CWL,
  input  logic [4:0] BL,
  output logic       rd_en,
  output logic       wr_en,
  output logic [2:0] beat_idx,
  output logic       rw_done,
  output logic       auto_pre,
  output logic       data_idle,
  output logic       q_full,
  output logic       cmd_overflow,
  output logic       data_conflict
);

  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;
  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [TS_W-1:0]   r_stamp;
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TS_W-1:0]   r_q_start [Q_DEPTH];
  logic              r_q_wr    [Q_DEPTH];
  logic              r_q_ap    [Q_DEPTH];
  logic [2:0]        r_q_last  [Q_DEPTH];
  logic              r_act_wr, r_act_ap;
  logic [2:0]        r_act_last;

  logic              w_legal, w_req, w_full, w_push, w_pop, w_ovf, w_is_wr, w_is_ap;
  logic [5:0]        w_lat_raw, w_lat;
  logic [TS_W-1:0]   w_new_start, w_diff;
  logic [2:0]        w_new_last, w_beat_nxt;
  logic              w_nonempty, w_late, w_due, w_start, w_conf;
  logic              w_rd_nxt, w_wr_nxt, w_done_nxt, w_ap_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(Q_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_legal     = (cas_req == RD_R) || (cas_req == RDA_R) || (cas_req == WR_R) || (cas_req == WRA_R);
  assign w_req       = cas_rdy && w_legal;
  assign w_full      = (r_cnt == CNT_W'(Q_DEPTH));
  assign w_push      = w_req && (!w_full || w_pop);
  assign w_ovf       = w_req && w_full && !w_pop;
  assign w_is_wr     = (cas_req == WR_R) || (cas_req == WRA_R);
  assign w_is_ap     = (cas_req == RDA_R) || (cas_req == WRA_R);
  assign w_lat_raw   = {1'b0, AL} + {1'b0, (w_is_wr ? CWL : CL)};
  assign w_lat       = (w_lat_raw < 6'd2) ? 6'd2 : w_lat_raw;
  assign w_new_start = r_stamp + TS_W'(w_lat);
`ifdef WR_CRC_EN
  assign w_new_last  = (BL == 5'd4) ? (w_is_wr ? 3'd2 : 3'd1) : (w_is_wr ? 3'd4 : 3'd3);
`else
  assign w_new_last  = (BL == 5'd4) ? 3'd1 : 3'd3;
`endif
  assign w_cnt_nxt   = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

  // Modulo distance to the head's start; MSB set means the start is already behind us.
  assign w_nonempty  = (r_cnt != '0);
  assign w_diff      = r_q_start[r_rd_ptr] - r_stamp;
  assign w_late      = w_diff[TS_W-1];
  assign w_due       = (w_diff == '0) || w_late;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = '0;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_ap_nxt    = 1'b0;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_conf      = 1'b0;
    case (r_state)
      D_IDLE: if (w_nonempty) w_state_nxt = D_WAIT;
      D_WAIT: begin
        if (!w_nonempty) w_state_nxt = D_IDLE;
        else if (w_due) begin
          w_start = 1'b1;
          w_conf  = w_late;
        end
      end
      D_BURST: begin
        if (r_beat_ne_last()) begin
          w_beat_nxt = beat_idx + 3'd1;
          w_rd_nxt   = !r_act_wr;
          w_wr_nxt   = r_act_wr;
          if (w_beat_nxt == r_act_last) begin
            w_done_nxt = 1'b1;
            w_ap_nxt   = r_act_ap;
            w_pop      = 1'b1;
          end
        end else if (w_nonempty && w_due) begin
          w_start = 1'b1;
          w_conf  = w_late;
        end else if (w_nonempty) w_state_nxt = D_WAIT;
        else w_state_nxt = D_IDLE;
      end
      default: w_state_nxt = D_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = D_BURST;
      w_beat_nxt  = '0;
      w_rd_nxt    = !r_q_wr[r_rd_ptr];
      w_wr_nxt    = r_q_wr[r_rd_ptr];
      if (r_q_last[r_rd_ptr] == 3'd0) begin
        w_done_nxt = 1'b1;
        w_ap_nxt   = r_q_ap[r_rd_ptr];
        w_pop      = 1'b1;
      end
    end
  end

  function automatic logic r_beat_ne_last();
    return beat_idx != r_act_last;
  endfunction

  always_ff @(posedge CK_t) begin
    if (w_push) begin
      r_q_start[r_wr_ptr] <= w_new_start;
      r_q_wr[r_wr_ptr]    <= w_is_wr;
      r_q_ap[r_wr_ptr]    <= w_is_ap;
      r_q_last[r_wr_ptr]  <= w_new_last;
    end
  end

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      r_state       <= D_IDLE;
      r_stamp       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_cnt         <= '0;
      r_act_wr      <= 1'b0;
      r_act_ap      <= 1'b0;
      r_act_last    <= '0;
      rd_en         <= 1'b0;
      wr_en         <= 1'b0;
      beat_idx      <= '0;
      rw_done       <= 1'b0;
      auto_pre      <= 1'b0;
      data_idle     <= 1'b1;
      q_full        <= 1'b0;
      cmd_overflow  <= 1'b0;
      data_conflict <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_stamp       <= r_stamp + 1'b1;
      r_cnt         <= w_cnt_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_start) begin
        r_act_wr   <= r_q_wr[r_rd_ptr];
        r_act_ap   <= r_q_ap[r_rd_ptr];
        r_act_last <= r_q_last[r_rd_ptr];
      end
      rd_en         <= w_rd_nxt;
      wr_en         <= w_wr_nxt;
      beat_idx      <= w_beat_nxt;
      rw_done       <= w_done_nxt;
      auto_pre      <= w_ap_nxt;
      data_idle     <= (w_cnt_nxt == '0) && (w_state_nxt == D_IDLE);
      q_full        <= (w_cnt_nxt == CNT_W'(Q_DEPTH));
      cmd_overflow  <= cmd_overflow | w_ovf;
      data_conflict <= data_conflict | w_conf;
    end
  end

endmodule

// File: tb/tb_ctrl_burst_data.sv
// Self-checking bench for ctrl_burst_data: reference scheduler fills a scoreboard of expected bursts,
// the per-cycle monitor in step() pops and compares them as windows open.
module tb_ctrl_burst_data;

  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;

  logic       CK_t = 1'b0;
  logic       reset_n = 1'b0;
  logic       cas_rdy = 1'b0;
  logic [2:0] cas_req = 3'd0;
  logic [4:0] CL = 5'd11, AL = 5'd0, CWL = 5'd9, BL = 5'd8;
  logic       rd_en, wr_en, rw_done, auto_pre, data_idle, q_full, cmd_overflow, data_conflict;
  logic [2:0] beat_idx;

  typedef struct {int start; bit wr; bit ap; int nb;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int   checks = 0, errors = 0, cyc = 0, tb_free = 0, last_start = 0;
  bit   in_burst = 0, exp_conf = 0;

  ctrl_burst_data dut (
    .CK_t(CK_t), .reset_n(reset_n), .cas_rdy(cas_rdy), .cas_req(cas_req),
    .CL(CL), .AL(AL), .CWL(CWL), .BL(BL),
    .rd_en(rd_en), .wr_en(wr_en), .beat_idx(beat_idx), .rw_done(rw_done), .auto_pre(auto_pre),
    .data_idle(data_idle), .q_full(q_full), .cmd_overflow(cmd_overflow), .data_conflict(data_conflict)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) cyc <= cyc + 1;

  // Advance one clock, then compare the DUT's window outputs against the scoreboard.
  task automatic step();
    int off;
    bit exp_done;
    @(negedge CK_t);
    if (!reset_n) begin
      in_burst = 0;
      return;
    end
    checks++;
    if (rd_en && wr_en) begin errors++; $display("FAIL rd_wr_excl got both high at cycle %0d", cyc); end
    if (rd_en || wr_en) begin
      if (beat_idx == 3'd0) begin
        checks++;
        if (in_burst) begin errors++; $display("FAIL burst_cut previous burst had no rw_done at cycle %0d", cyc); end
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_burst got window at cycle %0d want none", cyc);
          cur.start = cyc; cur.wr = wr_en; cur.ap = 1'b0; cur.nb = 4;
        end else begin
          cur = sb.pop_front();
          checks++;
          if (cyc != cur.start) begin errors++; $display("FAIL burst_start got %0d want %0d", cyc, cur.start); end
          checks++;
          if (wr_en !== cur.wr) begin errors++; $display("FAIL burst_dir got wr_en=%0b want %0b", wr_en, cur.wr); end
        end
        in_burst = 1;
      end else begin
        checks++;
        if (!in_burst) begin errors++; $display("FAIL orphan_beat got beat %0d at cycle %0d", beat_idx, cyc); end
      end
      off = cyc - cur.start;
      exp_done = (off == cur.nb - 1);
      checks++;
      if (beat_idx !== 3'(off)) begin errors++; $display("FAIL beat_idx got %0d want %0d", beat_idx, off); end
      checks++;
      if (rw_done !== exp_done) begin errors++; $display("FAIL rw_done got %0b want %0b cycle %0d", rw_done, exp_done, cyc); end
      checks++;
      if (auto_pre !== (exp_done && cur.ap)) begin errors++; $display("FAIL auto_pre got %0b want %0b", auto_pre, exp_done && cur.ap); end
      if (exp_done) in_burst = 0;
    end else begin
      checks++;
      if (rw_done !== 1'b0 || in_burst) begin
        errors++; $display("FAIL burst_trunc got rw_done=%0b in_burst=%0b at cycle %0d want idle window", rw_done, in_burst, cyc);
      end
      in_burst = 0;
    end
  endtask

  task automatic issue(input logic [2:0] req);
    exp_t e;
    int   n, lat, sched;
    n     = cyc + 1;
    e.wr  = (req == WR_R) || (req == WRA_R);
    e.ap  = (req == RDA_R) || (req == WRA_R);
    lat   = int'(AL) + (e.wr ? int'(CWL) : int'(CL));
    if (lat < 2) lat = 2;
    sched = n + lat;
    e.nb  = (BL == 5'd4) ? 2 : 4;
`ifdef WR_CRC_EN
    if (e.wr) e.nb = e.nb + 1;
`endif
    if (sched < tb_free) begin e.start = tb_free; exp_conf = 1; end
    else e.start = sched;
    tb_free = e.start + e.nb;
    last_start = e.start;
    sb.push_back(e);
    cas_req = req; cas_rdy = 1'b1;
    step();
    cas_rdy = 1'b0;
  endtask

  task automatic issue_drop(input logic [2:0] req);
    cas_req = req; cas_rdy = 1'b1;
    step();
    cas_rdy = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0 && !in_burst && data_idle) break;
      step();
    end
    checks++;
    if (sb.size() != 0 || in_burst || !data_idle) begin
      errors++; $display("FAIL %s_drain got %0d bursts pending idle=%0b want 0 and 1", name, sb.size(), data_idle);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    sb.delete(); tb_free = 0; exp_conf = 0; in_burst = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (rd_en !== 1'b0)         begin errors++; $display("FAIL rst_rd_en got %0b want 0", rd_en); end
    checks++; if (wr_en !== 1'b0)         begin errors++; $display("FAIL rst_wr_en got %0b want 0", wr_en); end
    checks++; if (beat_idx !== 3'd0)      begin errors++; $display("FAIL rst_beat got %0d want 0", beat_idx); end
    checks++; if (rw_done !== 1'b0)       begin errors++; $display("FAIL rst_rw_done got %0b want 0", rw_done); end
    checks++; if (auto_pre !== 1'b0)      begin errors++; $display("FAIL rst_auto_pre got %0b want 0", auto_pre); end
    checks++; if (data_idle !== 1'b1)     begin errors++; $display("FAIL rst_data_idle got %0b want 1", data_idle); end
    checks++; if (q_full !== 1'b0)        begin errors++; $display("FAIL rst_q_full got %0b want 0", q_full); end
    checks++; if (cmd_overflow !== 1'b0)  begin errors++; $display("FAIL rst_overflow got %0b want 0", cmd_overflow); end
    checks++; if (data_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict got %0b want 0", data_conflict); end
    reset_n = 1'b1;
    sb.delete(); tb_free = 0; exp_conf = 0;
  endtask

  task automatic test_single_read();
    int s;
    do_reset();
    CL = 5'd11; AL = 5'd0; BL = 5'd8;
    step(); step();
    issue(RD_R);
    s = last_start;
    for (int k = 0; k < 40 && cyc < s + 3; k++) step();
    checks++; if (data_idle !== 1'b0) begin errors++; $display("FAIL rd_idle_last got %0b want 0", data_idle); end
    step();
    checks++; if (cyc != s + 4 || data_idle !== 1'b1) begin errors++; $display("FAIL rd_idle_after got %0b at %0d want 1 at %0d", data_idle, cyc, s + 4); end
    wait_drain(10, "single_read");
  endtask

  task automatic test_write_ap();
    do_reset();
    CWL = 5'd9; AL = 5'd2; BL = 5'd8;
    issue(WRA_R);
    wait_drain(40, "write_ap");
    checks++; if (data_conflict !== 1'b0) begin errors++; $display("FAIL wr_conflict got %0b want 0", data_conflict); end
    AL = 5'd0;
  endtask

  task automatic test_seamless();
    int s1;
    do_reset();
    CL = 5'd11; AL = 5'd0; BL = 5'd8;
    issue(RD_R);
    s1 = last_start;
    step(); step(); step();
    issue(RD_R);
    for (int k = 0; k < 40 && cyc < s1; k++) step();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd_en !== 1'b1) begin errors++; $display("FAIL seamless_gap got rd_en=%0b at offset %0d want 1", rd_en, k); end
      step();
    end
    wait_drain(20, "seamless");
    checks++; if (data_conflict !== exp_conf) begin errors++; $display("FAIL seamless_conflict got %0b want %0b", data_conflict, exp_conf); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    CL = 5'd11; CWL = 5'd9; AL = 5'd0; BL = 5'd8;
    issue(RD_R);
    step(); step(); step();
    issue(WR_R);
    wait_drain(50, "back_to_back");
    checks++; if (data_conflict !== exp_conf) begin errors++; $display("FAIL b2b_conflict got %0b want %0b", data_conflict, exp_conf); end
  endtask

  task automatic test_overflow();
    do_reset();
    CL = 5'd20; AL = 5'd0; BL = 5'd8;
    for (int k = 0; k < 4; k++) issue(RD_R);
    checks++; if (q_full !== 1'b1)       begin errors++; $display("FAIL ovf_q_full got %0b want 1", q_full); end
    checks++; if (cmd_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", cmd_overflow); end
    issue_drop(RD_R);
    checks++; if (cmd_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", cmd_overflow); end
    wait_drain(80, "overflow");
    checks++; if (data_conflict !== exp_conf) begin errors++; $display("FAIL ovf_conflict got %0b want %0b", data_conflict, exp_conf); end
    checks++; if (cmd_overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got %0b want 1", cmd_overflow); end
  endtask

  task automatic test_clamp_bl4();
    do_reset();
    CL = 5'd1; AL = 5'd0; BL = 5'd4;
    issue(RDA_R);
    wait_drain(20, "clamp_rd");
    CWL = 5'd0;
    issue(WR_R);
    wait_drain(20, "clamp_wr");
    BL = 5'd8; CWL = 5'd9; CL = 5'd11;
  endtask

  task automatic test_illegal();
    do_reset();
    issue_drop(3'd0);
    issue_drop(3'd6);
    for (int k = 0; k < 20; k++) step();
    checks++; if (data_idle !== 1'b1) begin errors++; $display("FAIL illegal_idle got %0b want 1", data_idle); end
  endtask

  task automatic test_wrap();
    do_reset();
    CL = 5'd11; AL = 5'd0; BL = 5'd8;
    for (int k = 0; k < 250; k++) step();
    issue(RD_R);
    wait_drain(40, "wrap");
  endtask

  task automatic test_reset_mid();
    int s;
    do_reset();
    CL = 5'd11; AL = 5'd0; BL = 5'd8;
    issue(RD_R);
    s = last_start;
    for (int k = 0; k < 40 && cyc < s + 1; k++) step();
    checks++; if (beat_idx !== 3'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL mid_beat1 got beat %0d rd %0b want 1 1", beat_idx, rd_en); end
    reset_n = 1'b0;
    step();
    checks++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0 || beat_idx !== 3'd0 || rw_done !== 1'b0 || auto_pre !== 1'b0 || data_idle !== 1'b1 || q_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset got rd %0b wr %0b beat %0d done %0b idle %0b want 0 0 0 0 1", rd_en, wr_en, beat_idx, rw_done, data_idle);
    end
    reset_n = 1'b1;
    sb.delete(); tb_free = 0; exp_conf = 0;
    for (int k = 0; k < 5; k++) step();
    issue(RD_R);
    wait_drain(40, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_ap();
    test_seamless();
    test_back_to_back();
    test_overflow();
    test_clamp_bl4();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
